// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ frame requesters.
// Define UART_SCHED_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int CHAR_NR       = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*CHAR_NR*8-1:0]  char_array_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [CHAR_NR*8-1:0]          uart_char_array_o,
  output logic                          uart_update_o,
  input  logic                          uart_busy_i,
  output logic                          active_o,
  output logic                          err_o
);

  localparam int FW = CHAR_NR * 8;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_winner;
  logic [GW-1:0]       r_gapCnt;
  logic [TW-1:0]       r_toCnt;
  logic [PW-1:0]       w_winner;
  logic                w_found;
  logic                w_grant;

  assign w_grant  = (r_state == S_IDLE) && w_found && !uart_busy_i && !clr_i;
  assign active_o = (r_state != S_IDLE);

`ifdef UART_SCHED_FIXED_PRIO_EN
  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        w_winner = PW'(i);
        w_found  = 1'b1;
      end
    end
  end
`else
  localparam int SW = PW + 1;

  logic [PW-1:0] r_ptr;
  logic [SW-1:0] w_sum;

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + SW'(i);
      if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
      if (!w_found && req_i[w_sum[PW-1:0]]) begin
        w_winner = w_sum[PW-1:0];
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + PW'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_winner          <= '0;
      r_gapCnt          <= '0;
      r_toCnt           <= '0;
      grant_o           <= '0;
      done_o            <= '0;
      uart_char_array_o <= '0;
      uart_update_o     <= 1'b0;
      err_o             <= 1'b0;
    end else if (clr_i) begin
      // Abort keeps the last frame on the transmitter bus.
      r_state       <= S_IDLE;
      r_gapCnt      <= '0;
      r_toCnt       <= '0;
      grant_o       <= '0;
      done_o        <= '0;
      uart_update_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      grant_o <= '0;
      done_o  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            uart_char_array_o <= char_array_i[w_winner*FW +: FW];
            grant_o           <= ONE << w_winner;
            uart_update_o     <= 1'b1;
            r_winner          <= w_winner;
            r_toCnt           <= '0;
            r_state           <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (uart_busy_i) begin
            uart_update_o <= 1'b0;
            r_state       <= S_WAIT_DONE;
          end else if (r_toCnt == TW'(START_TIMEOUT - 1)) begin
            err_o         <= 1'b1;
            uart_update_o <= 1'b0;
            r_gapCnt      <= GW'(GAP_CYCLES);
            r_state       <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            r_toCnt <= r_toCnt + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!uart_busy_i) begin
            done_o   <= ONE << r_winner;
            r_gapCnt <= GW'(GAP_CYCLES);
            r_state  <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (r_gapCnt == '0) r_state <= S_IDLE;
          else                r_gapCnt <= r_gapCnt - GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CHAR_NR = 8;
  localparam int FW      = CHAR_NR * 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clr_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*FW-1:0]    char_array_i;
  logic [NUM_REQ-1:0]       grant_o;
  logic [NUM_REQ-1:0]       done_o;
  logic [FW-1:0]            uart_char_array_o;
  logic                     uart_update_o;
  logic                     uart_busy_i;
  logic                     active_o;
  logic                     err_o;

  logic [FW-1:0] frame [NUM_REQ];
  int compared   = 0;
  int mismatched = 0;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .CHAR_NR(CHAR_NR), .GAP_CYCLES(16), .START_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .clr_i(clr_i), .req_i(req_i), .char_array_i(char_array_i),
    .grant_o(grant_o), .done_o(done_o), .uart_char_array_o(uart_char_array_o),
    .uart_update_o(uart_update_o), .uart_busy_i(uart_busy_i),
    .active_o(active_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic clearPulse();
    req_i = '0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_i = 1'b0; req_i = '0; uart_busy_i = 1'b0;
    tick(); tick();
    compared++;
    if ({grant_o, done_o, uart_update_o, active_o, err_o} !== 11'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got g=%b d=%b u=%b a=%b e=%b want all 0",
               grant_o, done_o, uart_update_o, active_o, err_o);
    end
    compared++;
    if (uart_char_array_o !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_frame: got %h want 0", uart_char_array_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic sawDone;
    req_i = 4'b0010;
    tick();
    compared++;
    if (grant_o !== 4'b0010) begin
      mismatched++; $display("[TB] FAIL single_grant: got %b want 0010", grant_o);
    end
    compared++;
    if (uart_char_array_o !== frame[1]) begin
      mismatched++; $display("[TB] FAIL single_frame: got %h want %h", uart_char_array_o, frame[1]);
    end
    req_i = '0;
    tick();
    compared++;
    if ({grant_o, uart_update_o} !== 5'b0000_1) begin
      mismatched++; $display("[TB] FAIL single_pulse: got g=%b u=%b want 0000 1", grant_o, uart_update_o);
    end
    tick();
    compared++;
    if (uart_update_o !== 1'b1) begin
      mismatched++; $display("[TB] FAIL single_update_hold: got %b want 1", uart_update_o);
    end
    uart_busy_i = 1'b1;
    tick();
    compared++;
    if ({uart_update_o, active_o} !== 2'b01) begin
      mismatched++; $display("[TB] FAIL single_update_drop: got u=%b a=%b want 0 1", uart_update_o, active_o);
    end
    sawDone = 1'b0;
    for (int i = 0; i < 99; i++) begin
      tick();
      sawDone |= |done_o;
    end
    compared++;
    if (sawDone !== 1'b0) begin
      mismatched++; $display("[TB] FAIL single_early_done: got %b want 0", sawDone);
    end
    uart_busy_i = 1'b0;
    tick();
    compared++;
    if (done_o !== 4'b0010) begin
      mismatched++; $display("[TB] FAIL single_done: got %b want 0010", done_o);
    end
    tick();
    compared++;
    if ({done_o, active_o} !== 5'b0000_1) begin
      mismatched++; $display("[TB] FAIL single_gap: got d=%b a=%b want 0000 1", done_o, active_o);
    end
    repeat (15) tick();
    compared++;
    if (active_o !== 1'b1) begin
      mismatched++; $display("[TB] FAIL single_gap_end: got %b want 1", active_o);
    end
    tick();
    compared++;
    if (active_o !== 1'b0) begin
      mismatched++; $display("[TB] FAIL single_idle: got %b want 0", active_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expOneHot;
    int         idx;
    int         waited;
    resetPulse();
    req_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
`ifdef UART_SCHED_FIXED_PRIO_EN
      idx = 0;
`else
      idx = k % NUM_REQ;
`endif
      expOneHot = 4'b0001 << idx;
      waited = 0;
      tick();
      while (grant_o == 4'b0000 && waited < 40) begin
        tick();
        waited++;
      end
      compared++;
      if (grant_o !== expOneHot) begin
        mismatched++; $display("[TB] FAIL rr_grant%0d: got %b want %b", k, grant_o, expOneHot);
      end
      compared++;
      if (uart_char_array_o !== frame[idx]) begin
        mismatched++; $display("[TB] FAIL rr_frame%0d: got %h want %h", k, uart_char_array_o, frame[idx]);
      end
      uart_busy_i = 1'b1;
      repeat (3) tick();
      uart_busy_i = 1'b0;
      tick();
      compared++;
      if (done_o !== expOneHot) begin
        mismatched++; $display("[TB] FAIL rr_done%0d: got %b want %b", k, done_o, expOneHot);
      end
    end
    req_i = '0;
    repeat (20) tick();
  endtask

  task automatic test_timeout();
    int   count;
    logic sawDone;
    logic sawGrant;
    resetPulse();
    req_i = 4'b0001;
    uart_busy_i = 1'b0;
    tick();
    compared++;
    if (grant_o !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL to_grant: got %b want 0001", grant_o);
    end
    count = 0;
    sawDone = 1'b0;
    while (uart_update_o === 1'b1 && count < 200) begin
      count++;
      sawDone |= |done_o;
      tick();
    end
    compared++;
    if (count !== 64) begin
      mismatched++; $display("[TB] FAIL to_update_len: got %0d want 64", count);
    end
    compared++;
    if ({err_o, active_o} !== 2'b11) begin
      mismatched++; $display("[TB] FAIL to_err: got e=%b a=%b want 1 1", err_o, active_o);
    end
    sawGrant = 1'b0;
    repeat (17) begin
      tick();
      sawGrant |= |grant_o;
      sawDone  |= |done_o;
    end
    compared++;
    if (sawGrant !== 1'b0) begin
      mismatched++; $display("[TB] FAIL to_gap_grant: got %b want 0", sawGrant);
    end
    tick();
    compared++;
    if (grant_o !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL to_regrant: got %b want 0001", grant_o);
    end
    compared++;
    if ({err_o, sawDone} !== 2'b10) begin
      mismatched++; $display("[TB] FAIL to_sticky: got e=%b done_seen=%b want 1 0", err_o, sawDone);
    end
    req_i = '0;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    compared++;
    if ({err_o, active_o, uart_update_o} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL to_clear: got e=%b a=%b u=%b want 000", err_o, active_o, uart_update_o);
    end
    tick();
  endtask

  task automatic test_abort();
    logic sawAny;
    req_i = 4'b1000;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    compared++;
    if ({grant_o, active_o} !== 5'b0000_0) begin
      mismatched++; $display("[TB] FAIL ab_clr_wins: got g=%b a=%b want 0000 0", grant_o, active_o);
    end
    tick();
    compared++;
    if (grant_o !== 4'b1000) begin
      mismatched++; $display("[TB] FAIL ab_grant: got %b want 1000", grant_o);
    end
    uart_busy_i = 1'b1;
    tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    compared++;
    if ({active_o, done_o, uart_update_o, err_o} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL ab_idle: got a=%b d=%b u=%b e=%b want all 0", active_o, done_o, uart_update_o, err_o);
    end
    compared++;
    if (uart_char_array_o !== frame[3]) begin
      mismatched++; $display("[TB] FAIL ab_frame_kept: got %h want %h", uart_char_array_o, frame[3]);
    end
    sawAny = 1'b0;
    repeat (5) begin
      tick();
      sawAny |= (|grant_o) | (|done_o);
    end
    compared++;
    if (sawAny !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ab_blocked: got %b want 0", sawAny);
    end
    uart_busy_i = 1'b0;
    tick();
    compared++;
    if (grant_o !== 4'b1000) begin
      mismatched++; $display("[TB] FAIL ab_resume: got %b want 1000", grant_o);
    end
    clearPulse();
  endtask

  task automatic test_withdraw();
    logic sawGrant;
    req_i = 4'b0001;
    tick();
    compared++;
    if (grant_o !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL wd_grant0: got %b want 0001", grant_o);
    end
    req_i = '0;
    uart_busy_i = 1'b1;
    repeat (3) tick();
    uart_busy_i = 1'b0;
    tick();
    compared++;
    if (done_o !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL wd_done0: got %b want 0001", done_o);
    end
    req_i = 4'b0100;
    sawGrant = 1'b0;
    repeat (10) begin
      tick();
      sawGrant |= |grant_o;
    end
    req_i = '0;
    repeat (7) begin
      tick();
      sawGrant |= |grant_o;
    end
    uart_busy_i = 1'b1;
    req_i = 4'b0001;
    repeat (5) begin
      tick();
      sawGrant |= |grant_o;
    end
    compared++;
    if ({sawGrant, active_o} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL wd_no_grant: got seen=%b a=%b want 0 0", sawGrant, active_o);
    end
    uart_busy_i = 1'b0;
    tick();
    compared++;
    if (grant_o !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL wd_unblock: got %b want 0001", grant_o);
    end
    clearPulse();
  endtask

  task automatic test_reset_mid();
    req_i = 4'b0010;
    tick();
    compared++;
    if ({grant_o, uart_update_o} !== 5'b0010_1) begin
      mismatched++; $display("[TB] FAIL rm_grant: got g=%b u=%b want 0010 1", grant_o, uart_update_o);
    end
    req_i = 4'b1111;
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({grant_o, done_o, uart_update_o, active_o, err_o} !== 11'b0 || uart_char_array_o !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL rm_async: got g=%b d=%b u=%b a=%b e=%b f=%h want all 0",
               grant_o, done_o, uart_update_o, active_o, err_o, uart_char_array_o);
    end
    tick();
    rst = 1'b0;
    tick();
    compared++;
    if (grant_o !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL rm_first_grant: got %b want 0001", grant_o);
    end
    clearPulse();
  endtask

  initial begin
    frame[0] = "I=0.500A";
    frame[1] = "V=1.234V";
    frame[2] = "R=47.00K";
    frame[3] = "STAT:OK!";
    char_array_i = {frame[3], frame[2], frame[1], frame[0]};
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_abort();
    test_withdraw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
